icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the fetch stage and instruction memory. It serves single-word fetch requests from a tag/data array held in flops. On a miss it refills the whole line from a one-outstanding-request memory port, then returns the requested word. It also handles abort requests from pipeline flushes and whole-cache invalidation.

## Interface
- `ADDR_WIDTH`, 32, byte-address width.
- `INSTR_WIDTH`, 32, instruction and memory word width.
- `LINES`, 16, number of lines; power of 2, at least 2.
- `LINE_WORDS`, 4, words per line; power of 2, at least 2.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: fetch request. Sampled only in IDLE.
- `addr` in ADDR_WIDTH: fetch byte address. Bits [1:0] are ignored.
- `abort` in 1: pipeline flush. Cancels any response not yet presented.
- `inv` in 1: invalidate all lines.
- `rdata` out INSTR_WIDTH: returned instruction.
- `valid` out 1: one-cycle pulse; `rdata` is valid.
- `mem_req` out 1: memory read request. Held until accepted.
- `mem_addr` out ADDR_WIDTH: word-aligned read address.
- `mem_ready` in 1: request accepted this cycle.
- `mem_rdata` in INSTR_WIDTH: read data.
- `mem_rvalid` in 1: read data valid. At most one outstanding.
- `hit_count`, `miss_count` out 32: statistics counters (see Configuration).

## Operation
- Address split:
  - offset = addr[2 +: log2(LINE_WORDS)];
  - index = the next log2(LINES) bits;
  - tag = the remaining upper bits.
- Per line: one valid bit, one tag, and LINE_WORDS data words, all in flops.
- States: IDLE, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE:
  - `req` is high and the line is valid with a matching tag (hit): register the word, assert `valid` next cycle, stay in IDLE.
  - Miss: latch the address; beat counter = 0; go to REFILL_REQ.
- REFILL_REQ:
  - Drive `mem_req`=1 and `mem_addr` = {tag, index, beat, 2'b00}.
  - Hold both stable until `mem_ready`=1, then go to REFILL_WAIT.
- REFILL_WAIT:
  - On `mem_rvalid`=1, write `mem_rdata` into word[beat].
  - If beat == LINE_WORDS-1: set the line's valid bit and tag, go to RESPOND.
  - Otherwise: beat+1, go to REFILL_REQ.
  - Beats always run from 0 to LINE_WORDS-1; there is no critical-word-first ordering.
- RESPOND: drive `rdata` = word[offset] and `valid`=1 (unless aborted), go to IDLE.
- `req` outside IDLE is ignored. Fetch never issues while a request is pending.
- `abort`:
  - Sets a drop flag that suppresses the pending response. The refill still completes and the line becomes valid.
  - `abort` together with `req` in IDLE cancels that request's hit response.
  - The drop flag clears on return to IDLE.
  - A `valid` already presented in the abort cycle is not retracted.
- `inv`:
  - In IDLE: clears all valid bits at the next edge. A `req` in the same cycle is treated as a miss.
  - Outside IDLE: latched as pending. It is applied on entry to IDLE and also clears the line just refilled. The RESPOND data is still returned.

## Timing
- Reset values:
  - state IDLE;
  - all valid bits 0;
  - `valid`=0, `rdata`=0, `mem_req`=0, `mem_addr`=0;
  - drop flag and pending-inv flag 0;
  - counters 0.
- Tag and data arrays are not reset.
- Hit latency: `req` at cycle N gives `valid` at N+1. Back-to-back hits are possible each cycle.
- Miss latency: `req` at N, first `mem_req` at N+1. With zero-wait memory (`mem_ready` same cycle, `mem_rvalid` next cycle), `valid` arrives at N + 2·LINE_WORDS + 2.
- `mem_req` never drops or changes address before `mem_ready`.
- `mem_rvalid` outside REFILL_WAIT is ignored.
- `rst` mid-refill returns to IDLE at once and clears all valid bits. A later `mem_rvalid` for the abandoned beat is ignored.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on each accepted hit;
  - `miss_count` increments on each miss entering REFILL_REQ;
  - both wrap at 2^32 and are reset to 0.
- Not defined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Default parameters, cold cache. `req` at addr 0x104 → `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C → `valid` with `rdata` = the word returned for 0x104. With zero-wait memory, `valid` arrives 10 cycles after `req`.
- After the fill, `req` at 0x10C → `valid` the next cycle with the 0x10C word and no `mem_req`. `miss_count`=1 and `hit_count`=1 with `ICACHE_STATS_EN`.
- Conflict: fill 0x100, then `req` at 0x500 (same index, different tag) → refill 0x500–0x50C. A subsequent `req` at 0x100 misses again.
- `abort` during the second refill beat → no `valid` for that request. A subsequent `req` to the same line hits in 1 cycle.
- `mem_ready` held low for 5 cycles → `mem_req` and `mem_addr` stay stable throughout. Then `inv` during REFILL_WAIT → response still delivered, and the next `req` to the same address misses.
- `rst` asserted mid-refill → state IDLE with `mem_req`=0. A stray `mem_rvalid` is ignored, and `req` at 0x100 misses.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with whole-line refill, abort and invalidate.
// Build option ICACHE_STATS_EN adds wrapping hit/miss counters; otherwise both outputs are tied to 0.
module icache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int LINES       = 16,
    parameter int LINE_WORDS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic                   abort,
    input  logic                   inv,
    output logic [INSTR_WIDTH-1:0] rdata,
    output logic                   valid,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    input  logic                   mem_rvalid,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL_REQ,
        REFILL_WAIT,
        RESPOND
    } state_t;

    state_t state, state_next;

    // Lookup fields of the incoming fetch address
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       unused_addr_bits;

    assign req_off          = addr[2 +: OFF_W];
    assign req_idx          = addr[2 + OFF_W +: IDX_W];
    assign req_tag          = addr[ADDR_WIDTH-1 -: TAG_W];
    assign unused_addr_bits = addr[1:0];

    // Storage: valid bits are reset, tags and data are not
    logic [LINES-1:0]       line_valid;
    logic [TAG_W-1:0]       tags     [LINES];
    logic [INSTR_WIDTH-1:0] data_mem [LINES][LINE_WORDS];

    // Miss context held for the duration of a refill
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [OFF_W-1:0] miss_off;
    logic [OFF_W-1:0] beat, beat_next;
    logic             drop, drop_next;
    logic             inv_pend, inv_pend_next;

    logic                   valid_next;
    logic [INSTR_WIDTH-1:0] rdata_next;
    logic                   lookup_hit;
    logic                   start_miss;
    logic                   fill_we;
    logic                   fill_last;
    logic                   clear_all;

    always_comb begin
        state_next    = state;
        beat_next     = beat;
        drop_next     = drop;
        inv_pend_next = inv_pend;
        valid_next    = 1'b0;
        rdata_next    = rdata;
        lookup_hit    = 1'b0;
        start_miss    = 1'b0;
        fill_we       = 1'b0;
        fill_last     = 1'b0;
        clear_all     = 1'b0;

        case (state)
            IDLE: begin
                clear_all = inv;
                if (req) begin
                    // A same-cycle invalidate forces the lookup to miss
                    if (!inv && line_valid[req_idx] && (tags[req_idx] == req_tag)) begin
                        lookup_hit = 1'b1;
                        valid_next = !abort;
                        rdata_next = data_mem[req_idx][req_off];
                    end else begin
                        start_miss = 1'b1;
                        beat_next  = '0;
                        drop_next  = abort;
                        state_next = REFILL_REQ;
                    end
                end
            end
            REFILL_REQ: begin
                if (inv)   inv_pend_next = 1'b1;
                if (abort) drop_next     = 1'b1;
                if (mem_ready) state_next = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                if (inv)   inv_pend_next = 1'b1;
                if (abort) drop_next     = 1'b1;
                if (mem_rvalid) begin
                    fill_we = 1'b1;
                    if (beat == LAST_BEAT) begin
                        fill_last  = 1'b1;
                        state_next = RESPOND;
                    end else begin
                        beat_next  = beat + OFF_W'(1);
                        state_next = REFILL_REQ;
                    end
                end
            end
            RESPOND: begin
                // Data is returned even when an invalidate is pending; the
                // invalidate then also drops the line just filled.
                valid_next    = !(drop || abort);
                rdata_next    = data_mem[miss_idx][miss_off];
                clear_all     = inv_pend || inv;
                inv_pend_next = 1'b0;
                drop_next     = 1'b0;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            line_valid <= '0;
            beat       <= '0;
            drop       <= 1'b0;
            inv_pend   <= 1'b0;
            valid      <= 1'b0;
            rdata      <= '0;
        end else begin
            state    <= state_next;
            beat     <= beat_next;
            drop     <= drop_next;
            inv_pend <= inv_pend_next;
            valid    <= valid_next;
            rdata    <= rdata_next;
            if (clear_all) begin
                line_valid <= '0;
            end else if (fill_last) begin
                line_valid[miss_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_miss) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            miss_off <= req_off;
        end
        if (fill_we && !rst) begin
            data_mem[miss_idx][beat] <= mem_rdata;
        end
        if (fill_last && !rst) begin
            tags[miss_idx] <= miss_tag;
        end
    end

    assign mem_req  = (state == REFILL_REQ);
    assign mem_addr = mem_req ? {miss_tag, miss_idx, beat, 2'b00} : '0;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (lookup_hit) hit_count  <= hit_count + 32'd1;
            if (start_miss) miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written corner sequences,
// then randomized fetches checked against a line-address model of the cache contents.
module tb_icache;
    localparam int LW         = 4;
    localparam int NLINES     = 16;
    localparam int LINE_BYTES = LW * 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        abort;
    logic        inv;
    logic [31:0] rdata;
    logic        valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .LINES      (NLINES),
        .LINE_WORDS (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .abort     (abort),
        .inv       (inv),
        .rdata     (rdata),
        .valid     (valid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          nvalid;
    logic [31:0] vrdata;
    int          vcyc;
    int          beats_done;
    int          last_beat_cyc;
    logic [31:0] acc_q[$];
    int          stall_left  = 0;
    int          stall_total = 0;
    bit          rand_stall  = 0;
    bit          prev_stalled = 0;
    logic [31:0] prev_addr;
    bit          rv_pend = 0;
    logic [31:0] rv_addr = '0;

    // Cache model: per index, whether a line is held and its line base address
    bit          mv[NLINES];
    logic [31:0] mline[NLINES];
    int          m_hits = 0;
    int          m_misses = 0;

    typedef struct {
        logic [31:0] a;
        int          abort_at;
        int          inv_at;
        int          stall;
        bit          exp_hit;
        bit          exp_valid;
        int          exp_lat;
    } vec_t;

    vec_t tbl[15];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'((a / LINE_BYTES) % NLINES);
    endfunction

    function automatic logic [31:0] base_of(logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic bit model_hit(logic [31:0] a, int inv_at);
        return (inv_at != 1) && mv[idx_of(a)] && (mline[idx_of(a)] == base_of(a));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NLINES; i++) mv[i] = 1'b0;
    endfunction

    task automatic check_stats(string name);
`ifdef ICACHE_STATS_EN
        chk({name, "_hit_count"}, hit_count, m_hits);
        chk({name, "_miss_count"}, miss_count, m_misses);
`else
        chk({name, "_hit_count"}, hit_count, 32'd0);
        chk({name, "_miss_count"}, miss_count, 32'd0);
`endif
    endtask

    // One clock: memory responds from negedge, DUT outputs sampled at the next negedge
    task automatic tick();
        bit          acc;
        logic [31:0] acc_a;
        bit          drove_rv;
        if (prev_stalled) begin
            chk("mem_req_hold", mem_req, 1'b1);
            chk("mem_addr_hold", mem_addr, prev_addr);
        end
        drove_rv   = rv_pend;
        mem_rvalid = rv_pend;
        mem_rdata  = rv_pend ? mem_word(rv_addr) : 32'h0;
        mem_ready  = mem_req && (stall_left == 0);
        if (mem_req && stall_left != 0) begin
            stall_left--;
            stall_total++;
        end
        prev_stalled = mem_req && !mem_ready;
        prev_addr    = mem_addr;
        acc   = mem_ready;
        acc_a = mem_addr;
        if (acc) begin
            acc_q.push_back(acc_a);
            stall_left = rand_stall ? int'($urandom_range(0, 2)) : 0;
        end
        @(posedge clk);
        rv_pend = acc;
        rv_addr = acc_a;
        @(negedge clk);
        cyc++;
        if (drove_rv) begin
            beats_done++;
            last_beat_cyc = cyc;
        end
        if (valid) begin
            nvalid++;
            vrdata = rdata;
            vcyc   = cyc;
        end
    endtask

    // One fetch from IDLE; exp_lat < 0 means derive it from observed memory stalls
    task automatic do_fetch(input logic [31:0] a, input int abort_at, input int inv_at,
                            input int stall, input bit exp_hit, input bit exp_valid,
                            input int exp_lat, input string name);
        int t;
        int start;
        bit done;
        bit mh;
        int lat;
        nvalid      = 0;
        beats_done  = 0;
        acc_q.delete();
        stall_total = 0;
        stall_left  = stall;
        start = cyc;
        done  = 0;
        t     = 0;
        mh    = model_hit(a, inv_at);
        while (!done && t < 300) begin
            t++;
            req   = (t == 1);
            addr  = a;
            abort = (t == abort_at);
            inv   = (t == inv_at);
            tick();
            if (nvalid != 0) done = 1;
            else if (beats_done == LW && last_beat_cyc < cyc) done = 1;
            else if (exp_hit && t >= 3) done = 1;
        end
        req   = 1'b0;
        abort = 1'b0;
        inv   = 1'b0;
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_valid_cnt"}, nvalid, 32'(exp_valid));
        if (exp_valid && nvalid == 1) begin
            lat = (exp_lat >= 0) ? exp_lat : (exp_hit ? 1 : 2 * LW + 2 + stall_total);
            chk({name, "_rdata"}, vrdata, mem_word(a & ~32'h3));
            chk({name, "_latency"}, vcyc - start, lat);
        end
        chk({name, "_beats"}, acc_q.size(), exp_hit ? 0 : LW);
        if (!exp_hit && acc_q.size() == LW) begin
            for (int k = 0; k < LW; k++) chk({name, "_mem_addr"}, acc_q[k], base_of(a) + 32'(4 * k));
        end
        if (inv_at == 1) model_clear();
        if (mh) begin
            m_hits++;
        end else begin
            m_misses++;
            mv[idx_of(a)]    = 1'b1;
            mline[idx_of(a)] = base_of(a);
            if (inv_at > 1) model_clear();
        end
        check_stats(name);
    endtask

    logic [31:0] burst[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'h0000_0104, 0, 0, 0, 1'b0, 1'b1, 10};
        tbl[1]  = '{32'h0000_010C, 0, 0, 0, 1'b1, 1'b1, 1};
        tbl[2]  = '{32'h0000_0500, 0, 0, 0, 1'b0, 1'b1, 10};
        tbl[3]  = '{32'h0000_0100, 0, 0, 0, 1'b0, 1'b1, 10};
        tbl[4]  = '{32'h0000_0200, 4, 0, 0, 1'b0, 1'b0, 0};
        tbl[5]  = '{32'h0000_0204, 0, 0, 0, 1'b1, 1'b1, 1};
        tbl[6]  = '{32'h0000_0300, 0, 8, 5, 1'b0, 1'b1, 15};
        tbl[7]  = '{32'h0000_0300, 0, 0, 0, 1'b0, 1'b1, 10};
        tbl[8]  = '{32'h0000_0304, 0, 0, 0, 1'b1, 1'b1, 1};
        tbl[9]  = '{32'h0000_0308, 1, 0, 0, 1'b1, 1'b0, 0};
        tbl[10] = '{32'h0000_030C, 0, 1, 0, 1'b0, 1'b1, 10};
        tbl[11] = '{32'h0000_0304, 0, 0, 0, 1'b1, 1'b1, 1};
        tbl[12] = '{32'h0000_0104, 0, 0, 0, 1'b0, 1'b1, 10};
        tbl[13] = '{32'hFFFF_FFF8, 0, 0, 0, 1'b0, 1'b1, 10};
        tbl[14] = '{32'hFFFF_FFF3, 0, 0, 0, 1'b1, 1'b1, 1};

        rst = 1'b1; req = 1'b0; addr = '0; abort = 1'b0; inv = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        check_stats("rst");
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            do_fetch(tbl[i].a, tbl[i].abort_at, tbl[i].inv_at, tbl[i].stall,
                     tbl[i].exp_hit, tbl[i].exp_valid, tbl[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Back-to-back hits, one request per cycle
        burst[0] = 32'h0000_0100; burst[1] = 32'h0000_0108;
        burst[2] = 32'hFFFF_FFF4; burst[3] = 32'h0000_010C;
        acc_q.delete();
        for (int k = 0; k < 4; k++) begin
            req  = 1'b1;
            addr = burst[k];
            tick();
            chk("burst_valid", 32'(valid), 32'd1);
            chk("burst_rdata", rdata, mem_word(burst[k]));
            m_hits++;
        end
        req = 1'b0;
        tick();
        chk("burst_end_valid", 32'(valid), 32'd0);
        chk("burst_no_mem", acc_q.size(), 32'd0);
        check_stats("burst");

        // Reset in the middle of a refill, then a stray read return
        acc_q.delete();
        req = 1'b1; addr = 32'h0000_0600;
        tick();
        req = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_stalled = 0;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        rv_pend = 1'b1;
        rv_addr = 32'h0000_0604;
        tick();
        chk("stray_valid", 32'(valid), 32'd0);
        chk("stray_mem_req", 32'(mem_req), 32'd0);
        model_clear();
        m_hits = 0;
        m_misses = 0;
        check_stats("midrst");
        do_fetch(32'h0000_0100, 0, 0, 0, 1'b0, 1'b1, 10, "post_rst");
        do_fetch(32'h0000_0600, 0, 0, 0, 1'b0, 1'b1, 10, "post_rst2");

        // Randomized fetches against the model, with random memory stalls
        rand_stall = 1;
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [31:0] hi;
            int          sel;
            int          ia;
            int          ii;
            bit          h;
            sel = int'($urandom_range(0, 3));
            hi  = (sel == 3) ? 32'hF000_0000 : (32'(sel) << 8);
            a   = hi | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2)
                     | 32'($urandom_range(0, 3));
            ii = 0;
            if ($urandom_range(0, 9) == 0) ii = ($urandom_range(0, 1) == 0) ? 1 : int'($urandom_range(2, 8));
            h = model_hit(a, ii);
            if (h && ii > 1) ii = 0;
            ia = 0;
            if ($urandom_range(0, 7) == 0) ia = h ? 1 : int'($urandom_range(2, 9));
            do_fetch(a, ia, ii, int'($urandom_range(0, 2)), h, (ia == 0), -1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
